blink_scheduler: RTL and testbench

//  Run-control and configuration front end for the lamp-blink divider path.

---
 rtl/blink_scheduler.sv | 126 ++++++++++++
 tb/tb_blink_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/blink_scheduler.sv
// Run-control front end for the lamp-blink path: IDLE/RUN sequencer, programmable divide-by-N tick,
// valid/ready divisor load. Optional macro PATTERN_EN selects a rotating lamp pattern instead of a toggle.
module blink_scheduler #(
    parameter int          DIV_W       = 27,
    parameter int unsigned DEFAULT_DIV = 50000000,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic [7:0]       ld
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

`ifdef PATTERN_EN
    localparam logic [7:0] LD_RST = 8'h01;
`else
    localparam logic [7:0] LD_RST = 8'h00;
`endif

    logic [0:0]       state_r;
    logic [0:0]       state_next_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;
    logic             tick_r;
    logic [CNT_W-1:0] tick_cnt_r;
    logic [7:0]       ld_r;
    logic             period_end_s;
    logic             tick_next_s;
    logic             cfg_xfer_s;

    function automatic logic [7:0] ld_step(input logic [7:0] cur);
`ifdef PATTERN_EN
        return {cur[6:0], cur[7]};
`else
        return {7'b0000000, ~cur[0]};
`endif
    endfunction

    // Next-state selection; stop has priority over start in every state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (stop) begin
                    state_next_s = IDLE;
                end else if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    assign period_end_s = (state_r == RUN) && (cnt_r == (div_r - {{(DIV_W-1){1'b0}}, 1'b1}));
    assign tick_next_s  = period_end_s && !stop;
    assign cfg_xfer_s   = cfg_valid && (state_r == IDLE);

    // FSM state and divisor capture; a zero divisor is clamped to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            div_r   <= DIV_W'(DEFAULT_DIV);
        end else begin
            state_r <= state_next_s;
            if (cfg_xfer_s) begin
                div_r <= (cfg_div == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : cfg_div;
            end
        end
    end

    // Period counter only advances while staying in RUN, so every fresh run starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if ((state_r == RUN) && (state_next_s == RUN)) begin
            if (period_end_s) begin
                cnt_r <= {DIV_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= {DIV_W{1'b0}};
        end
    end

    // Tick pulse plus tick counter and lamps, all updated on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r     <= 1'b0;
            tick_cnt_r <= {CNT_W{1'b0}};
            ld_r       <= LD_RST;
        end else begin
            tick_r <= tick_next_s;
            if (tick_next_s) begin
                tick_cnt_r <= tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                ld_r       <= ld_step(ld_r);
            end
        end
    end

    assign cfg_ready = (state_r == IDLE);
    assign busy      = (state_r == RUN);
    assign tick      = tick_r;
    assign tick_cnt  = tick_cnt_r;
    assign ld        = ld_r;

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler: table of per-cycle vectors plus reset and counter-wrap sequences.
module tb_blink_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [26:0] cfg_div = 27'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic        tick;
    logic [15:0] tick_cnt;
    logic [7:0]  ld;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic        sp;
        logic        cv;
        logic [26:0] dv;
        logic        e_busy;
        logic        e_rdy;
        logic        e_tick;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    blink_scheduler dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .start(start), .stop(stop), .busy(busy),
        .tick(tick), .tick_cnt(tick_cnt), .ld(ld)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_ld(input logic [15:0] c);
        logic [7:0] v;
`ifdef PATTERN_EN
        v = 8'h01;
        v = v << c[2:0];
`else
        v = {7'b0000000, c[0]};
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic cv, input logic [26:0] dv,
                       input logic b, input logic r, input logic t, input logic [15:0] c);
        vec_t v;
        v.st = st; v.sp = sp; v.cv = cv; v.dv = dv;
        v.e_busy = b; v.e_rdy = r; v.e_tick = t; v.e_cnt = c;
        vecs.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_tick"}, {31'd0, tick}, 32'd0);
        check({tag, "_ready"}, {31'd0, cfg_ready}, 32'd1);
        check({tag, "_tick_cnt"}, {16'd0, tick_cnt}, 32'd0);
        check({tag, "_ld"}, {24'd0, ld}, {24'd0, exp_ld(16'd0)});
    endtask

    initial begin
        // divisor 4: ticks at cycles 4, 8, 12
        add(1'b1, 1'b0, 1'b1, 27'd4, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 16'(k));
            add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b1, 16'(k + 1));
        end
        // cfg_valid held in RUN is ignored; period remains 4
        for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 1'b1, 27'd9, 1'b1, 1'b0, 1'b0, 16'd3);
        add(1'b0, 1'b0, 1'b1, 27'd9, 1'b1, 1'b0, 1'b1, 16'd4);
        for (int j = 0; j < 2; j++) add(1'b0, 1'b0, 1'b1, 27'd9, 1'b1, 1'b0, 1'b0, 16'd4);
        add(1'b0, 1'b1, 1'b1, 27'd9, 1'b0, 1'b1, 1'b0, 16'd4);
        add(1'b0, 1'b0, 1'b1, 27'd9, 1'b0, 1'b1, 1'b0, 16'd4);
        add(1'b1, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 16'd4);
        for (int j = 0; j < 8; j++) add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 16'd4);
        add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b1, 16'd5);
        // divisor 0 and 1: tick every RUN cycle
        add(1'b0, 1'b1, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd5);
        add(1'b1, 1'b0, 1'b1, 27'd0, 1'b1, 1'b0, 1'b0, 16'd5);
        for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b1, 16'(6 + j));
        add(1'b0, 1'b1, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd8);
        add(1'b1, 1'b0, 1'b1, 27'd1, 1'b1, 1'b0, 1'b0, 16'd8);
        for (int j = 0; j < 2; j++) add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b1, 16'(9 + j));
        add(1'b0, 1'b1, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd10);
        // start+stop in IDLE, stop mid-period, restart gives a full period, start+stop in RUN
        add(1'b1, 1'b1, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd10);
        add(1'b1, 1'b0, 1'b1, 27'd4, 1'b1, 1'b0, 1'b0, 16'd10);
        for (int j = 0; j < 2; j++) add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 16'd10);
        add(1'b0, 1'b1, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd10);
        for (int j = 0; j < 2; j++) add(1'b0, 1'b0, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd10);
        add(1'b1, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 16'd10);
        for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 16'd10);
        add(1'b0, 1'b0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b1, 16'd11);
        add(1'b1, 1'b1, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd11);
        add(1'b0, 1'b0, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 16'd11);

        // reset state, with requests applied while reset is held
        #1;
        check_reset_outputs("reset_init");
        start = 1'b1; cfg_valid = 1'b1; cfg_div = 27'd2;
        @(posedge clk); #1;
        check("reset_hold_busy", {31'd0, busy}, 32'd0);
        start = 1'b0; cfg_valid = 1'b0; cfg_div = 27'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_release");

        foreach (vecs[i]) begin
            start = vecs[i].st; stop = vecs[i].sp;
            cfg_valid = vecs[i].cv; cfg_div = vecs[i].dv;
            @(posedge clk); #1;
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            check($sformatf("v%0d_ready", i), {31'd0, cfg_ready}, {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].e_tick});
            check($sformatf("v%0d_tick_cnt", i), {16'd0, tick_cnt}, {16'd0, vecs[i].e_cnt});
            check($sformatf("v%0d_ld", i), {24'd0, ld}, {24'd0, exp_ld(vecs[i].e_cnt)});
        end
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = 27'd0;

        // fresh reset, then tick counter wrap with divisor 1
        rst = 1'b1;
        #2;
        check_reset_outputs("reset_idle");
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b1; cfg_valid = 1'b1; cfg_div = 27'd1;
        @(posedge clk); #1;
        start = 1'b0; cfg_valid = 1'b0; cfg_div = 27'd0;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_pre_cnt", {16'd0, tick_cnt}, 32'h0000FFFF);
        check("wrap_pre_ld", {24'd0, ld}, {24'd0, exp_ld(16'hFFFF)});
        check("wrap_pre_tick", {31'd0, tick}, 32'd1);
        @(posedge clk); #1;
        check("wrap_post_cnt", {16'd0, tick_cnt}, 32'h00000000);
        check("wrap_post_ld", {24'd0, ld}, {24'd0, exp_ld(16'h0000)});
        @(posedge clk); #1;
        check("wrap_next_cnt", {16'd0, tick_cnt}, 32'h00000001);

        // reset asserted mid-cycle during RUN takes effect without a clock edge
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_midrun");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
